// File: rtl/instr_mem_ctrl.sv
// Clocked instruction memory with request/response handshake, wait states and fault flagging.
// Optional misaligned-fetch faulting is enabled by defining INSTR_MEM_ALIGN_CHECK_EN.
module instr_mem_ctrl #(
  parameter int unsigned DEPTH       = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic        Flush,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspInstr,
  output logic [31:0] RspAddr,
  output logic        RspFault
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [32:0] BASE_33   = {1'b0, BASE_ADDR};
`ifdef INSTR_MEM_ALIGN_CHECK_EN
  localparam logic [32:0] SPAN      = 33'(4 * DEPTH) - 33'd4;
`else
  // Byte offsets inside the last word still belong to that word.
  localparam logic [32:0] SPAN      = 33'(4 * DEPTH) - 33'd1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic        rsp_fault_q, rsp_fault_d;

  logic [31:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  logic [32:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          misalign;
  logic          accept;

  // 33-bit subtraction: bit 32 set means the address is below the base.
  assign offset   = {1'b0, ReqAddr} - BASE_33;
  assign idx      = AW'(offset >> 2);
  assign in_range = !offset[32] && (offset <= SPAN);
`ifdef INSTR_MEM_ALIGN_CHECK_EN
  assign misalign = |ReqAddr[1:0];
`else
  assign misalign = 1'b0;
`endif
  assign accept   = ReqValid && ReqReady;

  assign rsp_fault_d = !in_range || misalign;
  assign rsp_instr_d = rsp_fault_d ? FAULT_INSTR : mem[idx];
  assign rsp_addr_d  = ReqAddr;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (state_q == S_HOLD && RspReady) state_d = S_IDLE;
          if (accept) begin
            if (WAIT_CYCLES > 0) begin
              state_d = S_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_d = S_HOLD;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    RspValid = (state_q == S_HOLD);
    ReqReady = !Flush && ((state_q == S_IDLE) || ((state_q == S_HOLD) && RspReady));
  end

  // Response payload is captured at acceptance and held until the next acceptance.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rsp_instr_q <= 32'h0;
      rsp_addr_q  <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else if (accept) begin
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign RspInstr = rsp_instr_q;
  assign RspAddr  = rsp_addr_q;
  assign RspFault = rsp_fault_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: one zero-wait instance and one three-wait instance
// with a non-zero base address.
module tb_instr_mem_ctrl;

  localparam logic [31:0] A_BASE  = 32'h0000_0000;
  localparam int          A_DEPTH = 128;
  localparam logic [31:0] A_FI    = 32'hDEAD_BEEF;
  localparam logic [31:0] B_BASE  = 32'h0000_1000;
  localparam int          B_DEPTH = 16;
  localparam logic [31:0] B_FI    = 32'h0BAD_F00D;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset;
  logic        a_ReqValid, a_ReqReady, a_Flush, a_RspValid, a_RspReady, a_RspFault;
  logic [31:0] a_ReqAddr, a_RspInstr, a_RspAddr;
  logic        b_ReqValid, b_ReqReady, b_Flush, b_RspValid, b_RspReady, b_RspFault;
  logic [31:0] b_ReqAddr, b_RspInstr, b_RspAddr;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  instr_mem_ctrl #(.DEPTH(A_DEPTH), .BASE_ADDR(A_BASE), .WAIT_CYCLES(0), .FAULT_INSTR(A_FI)) u_a (
    .CLK(CLK), .Reset(Reset), .ReqValid(a_ReqValid), .ReqReady(a_ReqReady), .ReqAddr(a_ReqAddr),
    .Flush(a_Flush), .RspValid(a_RspValid), .RspReady(a_RspReady), .RspInstr(a_RspInstr),
    .RspAddr(a_RspAddr), .RspFault(a_RspFault)
  );

  instr_mem_ctrl #(.DEPTH(B_DEPTH), .BASE_ADDR(B_BASE), .WAIT_CYCLES(3), .FAULT_INSTR(B_FI)) u_b (
    .CLK(CLK), .Reset(Reset), .ReqValid(b_ReqValid), .ReqReady(b_ReqReady), .ReqAddr(b_ReqAddr),
    .Flush(b_Flush), .RspValid(b_RspValid), .RspReady(b_RspReady), .RspInstr(b_RspInstr),
    .RspAddr(b_RspAddr), .RspFault(b_RspFault)
  );

  function automatic logic [31:0] img(input int unsigned i);
    if (i == 0) return 32'hE200_0000;
    if (i == 1) return 32'hE590_1001;
    return 32'h1000_0000 + i * 32'h0000_0101;
  endfunction

  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] base,
                                 input int depth, input logic [31:0] fi);
    exp_t        e;
    logic [32:0] a33, lo, hi;
    logic        ok;
    a33 = {1'b0, addr};
    lo  = {1'b0, base};
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    hi  = lo + 33'(4 * depth) - 33'd4;
    ok  = (a33 >= lo) && (a33 <= hi) && (addr[1:0] == 2'b00);
`else
    hi  = lo + 33'(4 * depth) - 33'd1;
    ok  = (a33 >= lo) && (a33 <= hi);
`endif
    e.addr  = addr;
    e.fault = !ok;
    e.instr = ok ? img((addr - base) >> 2) : fi;
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      if (!Reset) begin
        if (a_RspValid && a_RspReady) begin
          tests++;
          if (q_a.size() == 0) begin
            fails++;
            $display("FAIL a_unexpected_rsp: got addr %h instr %h, required no response", a_RspAddr, a_RspInstr);
          end else begin
            automatic exp_t e = q_a.pop_front();
            if (a_RspAddr !== e.addr || a_RspInstr !== e.instr || a_RspFault !== e.fault) begin
              fails++;
              $display("FAIL a_rsp: got addr %h instr %h fault %b, required addr %h instr %h fault %b",
                       a_RspAddr, a_RspInstr, a_RspFault, e.addr, e.instr, e.fault);
            end
          end
        end
        if (a_Flush) q_a.delete();
        if (a_ReqValid && a_ReqReady) q_a.push_back(model(a_ReqAddr, A_BASE, A_DEPTH, A_FI));
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (!Reset) begin
        if (b_RspValid && b_RspReady) begin
          tests++;
          if (q_b.size() == 0) begin
            fails++;
            $display("FAIL b_unexpected_rsp: got addr %h instr %h, required no response", b_RspAddr, b_RspInstr);
          end else begin
            automatic exp_t e = q_b.pop_front();
            if (b_RspAddr !== e.addr || b_RspInstr !== e.instr || b_RspFault !== e.fault) begin
              fails++;
              $display("FAIL b_rsp: got addr %h instr %h fault %b, required addr %h instr %h fault %b",
                       b_RspAddr, b_RspInstr, b_RspFault, e.addr, e.instr, e.fault);
            end
          end
        end
        if (b_Flush) q_b.delete();
        if (b_ReqValid && b_ReqReady) q_b.push_back(model(b_ReqAddr, B_BASE, B_DEPTH, B_FI));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_a(input logic v, input logic [31:0] ad, input logic rr, input logic fl);
    @(posedge CLK); #2;
    a_ReqValid = v; a_ReqAddr = ad; a_RspReady = rr; a_Flush = fl;
    @(negedge CLK);
  endtask

  task automatic step_b(input logic v, input logic [31:0] ad, input logic rr, input logic fl);
    @(posedge CLK); #2;
    b_ReqValid = v; b_ReqAddr = ad; b_RspReady = rr; b_Flush = fl;
    @(negedge CLK);
  endtask

  task automatic fetch_a(input logic [31:0] ad);
    int k = 0;
    step_a(1'b1, ad, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (a_RspValid !== 1'b1) begin
      fails++;
      $display("FAIL a_fetch_latency: got RspValid %b, required 1 (addr %h)", a_RspValid, ad);
    end
  endtask

  task automatic fetch_b(input logic [31:0] ad);
    int k = 0;
    step_b(1'b1, ad, 1'b1, 1'b0);
    step_b(1'b0, 32'h0, 1'b1, 1'b0);
    k = 1;
    while (!b_RspValid && k < 20) begin
      step_b(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    tests++;
    if (b_RspValid !== 1'b1) begin
      fails++;
      $display("FAIL b_fetch_timeout: got no response after %0d cycles, required one (addr %h)", k, ad);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    tests++;
    if ({a_RspValid, a_RspFault, a_RspInstr, a_RspAddr} !== 66'h0) begin
      fails++;
      $display("FAIL reset_outputs: got valid %b fault %b instr %h addr %h, required all 0",
               a_RspValid, a_RspFault, a_RspInstr, a_RspAddr);
    end
    tests++;
    if (a_ReqReady !== 1'b1 || b_ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_reqready: got %b/%b, required 1/1", a_ReqReady, b_ReqReady);
    end
    a_Flush = 1'b1; b_Flush = 1'b1;
    #1;
    tests++;
    if (a_ReqReady !== 1'b0 || b_ReqReady !== 1'b0) begin
      fails++;
      $display("FAIL reset_reqready_flush: got %b/%b, required 0/0", a_ReqReady, b_ReqReady);
    end
    a_Flush = 1'b0; b_Flush = 1'b0;
    @(posedge CLK); #2;
    Reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    step_a(1'b1, 32'h0, 1'b1, 1'b0);
    step_a(1'b1, 32'h4, 1'b1, 1'b0);
    tests++;
    if (a_RspValid !== 1'b1 || a_RspInstr !== 32'hE200_0000) begin
      fails++;
      $display("FAIL b2b_first: got valid %b instr %h, required 1 E2000000", a_RspValid, a_RspInstr);
    end
    step_a(1'b1, 32'h8, 1'b1, 1'b0);
    tests++;
    if (a_RspValid !== 1'b1 || a_RspInstr !== 32'hE590_1001 || a_RspFault !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: got valid %b instr %h fault %b, required 1 E5901001 0",
               a_RspValid, a_RspInstr, a_RspFault);
    end
    for (int i = 0; i < 8; i++) begin
      step_a(1'b1, 32'($urandom_range(0, A_DEPTH - 1)) << 2, 1'b1, 1'b0);
      tests++;
      if (a_RspValid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_stream: got RspValid %b at beat %0d, required 1", a_RspValid, i);
      end
    end
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_range;
    fetch_a(32'h0000_01FC);
    fetch_a(32'h0000_0200);
    fetch_a(32'hFFFF_FFFC);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_misaligned;
    fetch_a(32'h0000_0006);
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    step_a(1'b1, 32'h8, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, 32'hC, 1'b0, 1'b0);
      tests++;
      if (a_RspValid !== 1'b1 || a_RspAddr !== 32'h8 || a_RspInstr !== img(2) ||
          a_RspFault !== 1'b0 || a_ReqReady !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: got valid %b addr %h instr %h fault %b rdy %b, required 1 00000008 %h 0 0",
                 a_RspValid, a_RspAddr, a_RspInstr, a_RspFault, a_ReqReady, img(2));
      end
    end
    step_a(1'b1, 32'hC, 1'b1, 1'b0);
    tests++;
    if (a_ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_accept: got ReqReady %b, required 1", a_ReqReady);
    end
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (a_RspValid !== 1'b1 || a_RspAddr !== 32'hC) begin
      fails++;
      $display("FAIL bp_next_rsp: got valid %b addr %h, required 1 0000000c", a_RspValid, a_RspAddr);
    end
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_wait;
    int  k    = 0;
    logic seen = 1'b0;
    step_b(1'b1, 32'h0000_1004, 1'b1, 1'b0);
    while (!seen && k < 20) begin
      step_b(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
      if (b_RspValid) seen = 1'b1;
      else begin
        tests++;
        if (b_ReqReady !== 1'b0) begin
          fails++;
          $display("FAIL wait_reqready: got %b during WAIT cycle %0d, required 0", b_ReqReady, k);
        end
      end
    end
    tests++;
    if (k != 4 || !seen) begin
      fails++;
      $display("FAIL wait_latency: got %0d cycles (seen %b), required 4", k, seen);
    end
    step_b(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_wait_throughput;
    int k = 0;
    step_b(1'b1, 32'h0000_1008, 1'b1, 1'b0);
    repeat (3) step_b(1'b0, 32'h0, 1'b1, 1'b0);
    step_b(1'b1, 32'h0000_100C, 1'b1, 1'b0);
    tests++;
    if (b_RspValid !== 1'b1 || b_ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL tput_hold_accept: got valid %b rdy %b, required 1 1", b_RspValid, b_ReqReady);
    end
    k = 0;
    do begin
      step_b(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end while (!b_RspValid && k < 20);
    tests++;
    if (k != 4) begin
      fails++;
      $display("FAIL tput_period: got %0d cycles, required 4", k);
    end
    step_b(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_range_base;
    fetch_b(32'h0000_103C);
    fetch_b(32'h0000_1040);
    fetch_b(32'h0000_0FFC);
    fetch_b(32'h0000_1000);
    step_b(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush;
    int k = 0;
    logic seen = 1'b0;
    step_b(1'b1, 32'h0000_1010, 1'b1, 1'b0);
    step_b(1'b0, 32'h0, 1'b1, 1'b0);
    step_b(1'b1, 32'h0000_1014, 1'b1, 1'b1);
    tests++;
    if (b_ReqReady !== 1'b0) begin
      fails++;
      $display("FAIL flush_reqready: got %b with Flush, required 0", b_ReqReady);
    end
    step_b(1'b0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (b_ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL flush_wait_idle: got ReqReady %b after flush, required 1", b_ReqReady);
    end
    for (int i = 0; i < 6; i++) begin
      step_b(1'b0, 32'h0, 1'b1, 1'b0);
      if (b_RspValid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_wait_norsp: got a response after flush in WAIT, required none");
    end
    step_b(1'b1, 32'h0000_1018, 1'b0, 1'b0);
    k = 0;
    do begin
      step_b(1'b0, 32'h0, 1'b0, 1'b0);
      k++;
    end while (!b_RspValid && k < 20);
    tests++;
    if (b_RspValid !== 1'b1) begin
      fails++;
      $display("FAIL flush_hold_reach: got no HOLD after %0d cycles, required RspValid 1", k);
    end
    step_b(1'b0, 32'h0, 1'b0, 1'b1);
    step_b(1'b0, 32'h0, 1'b1, 1'b0);
    tests++;
    if (b_RspValid !== 1'b0 || b_ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL flush_hold_idle: got valid %b rdy %b, required 0 1", b_RspValid, b_ReqReady);
    end
    repeat (2) step_b(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midflight;
    logic seen = 1'b0;
    step_b(1'b1, 32'h0000_1020, 1'b1, 1'b0);
    step_a(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    b_ReqValid = 1'b0;
    step_a(1'b0, 32'h0, 1'b0, 1'b0);
    tests++;
    if (a_RspValid !== 1'b1 || a_RspFault !== 1'b1 || a_RspInstr !== A_FI) begin
      fails++;
      $display("FAIL midreset_setup: got valid %b fault %b instr %h, required 1 1 %h",
               a_RspValid, a_RspFault, a_RspInstr, A_FI);
    end
    @(posedge CLK); #2;
    Reset = 1'b1;
    @(negedge CLK);
    tests++;
    if ({a_RspValid, a_RspFault, a_RspInstr, a_RspAddr, b_RspValid} !== 67'h0) begin
      fails++;
      $display("FAIL midreset_outputs: got a valid %b fault %b instr %h addr %h b valid %b, required all 0",
               a_RspValid, a_RspFault, a_RspInstr, a_RspAddr, b_RspValid);
    end
    q_a.delete();
    q_b.delete();
    @(posedge CLK); #2;
    Reset = 1'b0;
    a_RspReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step_b(1'b0, 32'h0, 1'b1, 1'b0);
      if (b_RspValid || a_RspValid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL midreset_replay: got a response after reset, required none");
    end
  endtask

  initial begin
    Reset = 1'b1;
    a_ReqValid = 1'b0; a_ReqAddr = 32'h0; a_RspReady = 1'b1; a_Flush = 1'b0;
    b_ReqValid = 1'b0; b_ReqAddr = 32'h0; b_RspReady = 1'b1; b_Flush = 1'b0;
    #1;
    for (int i = 0; i < A_DEPTH; i++) u_a.mem[i] = img(i);
    for (int i = 0; i < B_DEPTH; i++) u_b.mem[i] = img(i);

    test_reset;
    test_back_to_back;
    test_range;
    test_misaligned;
    test_backpressure;
    test_wait;
    test_wait_throughput;
    test_range_base;
    test_flush;
    test_reset_midflight;

    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL pending_rsp: got %0d/%0d undelivered responses, required 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
